// File: rtl/keypad_event.sv
// keypad_event: key-event detector between the keypad scanner and the
// display/command logic. It classifies each scan sample and debounces press
// and release. It emits one-cycle press/release strobes together with the
// encoded key position. A held key produces exactly one fresh press.
//
// Build option: define KEYPAD_EVENT_REPEAT_EN to enable typematic
// auto-repeat (REPEAT_DELAY samples to the first repeat, then every
// REPEAT_RATE samples). Without it, is_repeat is always 0.
//
// The release strobe port is named key_release because "release" is a
// reserved word in SystemVerilog.

module keypad_event #(
    parameter int NROWS        = 4,
    parameter int NCOLS        = 4,
    parameter int DEBOUNCE     = 3,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     scan_valid,
    input  logic [NROWS-1:0]         rows,
    input  logic [NCOLS-1:0]         cols,
    output logic                     press,
    output logic                     is_repeat,
    output logic                     key_release,
    output logic                     held,
    output logic [$clog2(NROWS)-1:0] key_row,
    output logic [$clog2(NCOLS)-1:0] key_col
);

    localparam int RW    = $clog2(NROWS);
    localparam int CLW   = $clog2(NCOLS);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_REL
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [RW-1:0]    cand_row;
    logic [CLW-1:0]   cand_col;
    logic [RW-1:0]    row_idx;
    logic [CLW-1:0]   col_idx;
    logic             is_none;
    logic             is_single;
    logic             same_key;
    logic             debounced;

    // Encode the index of the set row and column bit (meaningful for SINGLE samples only)
    always_comb begin
        // NOTE: every combinational output gets a default before the loops so no latch is inferred.
        row_idx = '0;
        col_idx = '0;
        for (int i = 0; i < NROWS; i++) begin
            if (rows[i]) row_idx = RW'(i);
        end
        for (int j = 0; j < NCOLS; j++) begin
            if (cols[j]) col_idx = CLW'(j);
        end
    end

    assign is_none   = (rows == '0);
    assign is_single = $onehot(rows) && $onehot(cols);
    assign same_key  = (row_idx == cand_row) && (col_idx == cand_col);
    assign cnt_inc   = cnt + CNT_W'(1);
    assign debounced = (cnt_inc == CNT_W'(DEBOUNCE));

`ifdef KEYPAD_EVENT_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW  = $clog2(RMAX + 1);

    logic [RCW-1:0] rcnt;
    logic           rep_started;
    logic [RCW-1:0] rep_limit;
    logic [RCW:0]   rcnt_inc;
    logic           rep_due;
    logic [RCW-1:0] rcnt_sat;

    // The first repeat waits REPEAT_DELAY samples, later ones REPEAT_RATE.
    // rcnt_inc is one bit wider so the compare cannot wrap at the top of the range.
    assign rep_limit = rep_started ? RCW'(REPEAT_RATE) : RCW'(REPEAT_DELAY);
    assign rcnt_inc  = {1'b0, rcnt} + (RCW+1)'(1);
    assign rep_due   = (rcnt_inc >= {1'b0, rep_limit});
    // Saturating at the limit keeps a due repeat pending through a release bounce.
    assign rcnt_sat  = rep_due ? rep_limit : rcnt_inc[RCW-1:0];
`else
    // Constant 0 without the repeat feature; the parameters stay in the shared parameter list.
    assign is_repeat = (REPEAT_DELAY < 0) && (REPEAT_RATE < 0);
`endif

    // Debounce FSM with registered strobes, key position and held flag
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
            state       <= IDLE;
            cnt         <= '0;
            cand_row    <= '0;
            cand_col    <= '0;
            press       <= 1'b0;
            key_release <= 1'b0;
            held        <= 1'b0;
            key_row     <= '0;
            key_col     <= '0;
`ifdef KEYPAD_EVENT_REPEAT_EN
            is_repeat   <= 1'b0;
            rcnt        <= '0;
            rep_started <= 1'b0;
`endif
        end else begin
            // Strobes last one cycle unless re-asserted below
            press       <= 1'b0;
            key_release <= 1'b0;
`ifdef KEYPAD_EVENT_REPEAT_EN
            is_repeat   <= 1'b0;
`endif
            if (scan_valid) begin
                unique case (state)
                    IDLE: begin
                        if (is_single) begin
                            cand_row <= row_idx;
                            cand_col <= col_idx;
                            cnt      <= CNT_W'(1);
                            if (DEBOUNCE == 1) begin
                                state   <= HELD;
                                held    <= 1'b1;
                                press   <= 1'b1;
                                key_row <= row_idx;
                                key_col <= col_idx;
`ifdef KEYPAD_EVENT_REPEAT_EN
                                rcnt        <= '0;
                                rep_started <= 1'b0;
`endif
                            end else begin
                                state <= DEB_PRESS;
                            end
                        end
                    end

                    DEB_PRESS: begin
                        if (!is_single) begin
                            state <= IDLE;
                        end else if (!same_key) begin
                            cand_row <= row_idx;
                            cand_col <= col_idx;
                            cnt      <= CNT_W'(1);
                        end else begin
                            cnt <= cnt_inc;
                            if (debounced) begin
                                state   <= HELD;
                                held    <= 1'b1;
                                press   <= 1'b1;
                                key_row <= row_idx;
                                key_col <= col_idx;
`ifdef KEYPAD_EVENT_REPEAT_EN
                                rcnt        <= '0;
                                rep_started <= 1'b0;
`endif
                            end
                        end
                    end

                    HELD: begin
                        // Any SINGLE or MULTI sample keeps the key held; a different key is ignored
                        if (is_none) begin
                            cnt <= CNT_W'(1);
                            if (DEBOUNCE == 1) begin
                                state       <= IDLE;
                                held        <= 1'b0;
                                key_release <= 1'b1;
                            end else begin
                                state <= DEB_REL;
                            end
                        end
`ifdef KEYPAD_EVENT_REPEAT_EN
                        // An immediate release (DEBOUNCE=1) suppresses a due repeat
                        if (rep_due && !(is_none && DEBOUNCE == 1)) begin
                            press       <= 1'b1;
                            is_repeat   <= 1'b1;
                            rcnt        <= '0;
                            rep_started <= 1'b1;
                        end else begin
                            rcnt <= rcnt_sat;
                        end
`endif
                    end

                    DEB_REL: begin
                        if (!is_none) begin
                            state <= HELD;
                        end else if (debounced) begin
                            state       <= IDLE;
                            held        <= 1'b0;
                            key_release <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
`ifdef KEYPAD_EVENT_REPEAT_EN
                        rcnt <= rcnt_sat;
`endif
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_event.sv
// tb_keypad_event: directed stimulus for keypad_event with a scoreboard.
// Stimulus pushes each expected strobe (kind, repeat flag, key, held, cycle)
// into a queue. A monitor pops and compares whenever press or release appears.
// It also flags strobes that nobody expected and expected strobes that never came.
// Repeat expectations follow KEYPAD_EVENT_REPEAT_EN.

module tb_keypad_event;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_valid;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       press;
    logic       is_repeat;
    logic       key_release;
    logic       held;
    logic [1:0] key_row;
    logic [1:0] key_col;

    keypad_event #(
        .NROWS       (4),
        .NCOLS       (4),
        .DEBOUNCE    (3),
        .REPEAT_DELAY(16),
        .REPEAT_RATE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_valid (scan_valid),
        .rows       (rows),
        .cols       (cols),
        .press      (press),
        .is_repeat  (is_repeat),
        .key_release(key_release),
        .held       (held),
        .key_row    (key_row),
        .key_col    (key_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rel;
        logic       rep;
        logic [1:0] row;
        logic [1:0] col;
        logic       hld;
        int         due;
    } ev_t;

    ev_t exp_q[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Expect a strobe from the sample just driven: visible at the next negedge
    task automatic expect_ev(input logic rel, input logic rep, input logic [1:0] row,
                             input logic [1:0] col, input logic hld);
        ev_t e;
        e.rel = rel;
        e.rep = rep;
        e.row = row;
        e.col = col;
        e.hld = hld;
        e.due = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic smp(input logic [3:0] r, input logic [3:0] c);
        @(negedge clk);
        scan_valid = 1'b1;
        rows       = r;
        cols       = c;
    endtask

    // Idle cycles drive NONE with scan_valid low, so a leak would abort a debounce
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            scan_valid = 1'b0;
            rows       = 4'b0000;
            cols       = 4'b0000;
        end
    endtask

    task automatic do_reset(input logic [3:0] r, input logic [3:0] c);
        @(negedge clk);
        reset      = 1'b1;
        scan_valid = 1'b1;
        rows       = r;
        cols       = c;
        @(negedge clk);
        reset      = 1'b0;
        scan_valid = 1'b0;
        rows       = 4'b0000;
        cols       = 4'b0000;
        check("reset_outputs", 32'({press, is_repeat, key_release, held, key_row, key_col}), 0);
    endtask

    // Monitor: compare every strobe against the head of the scoreboard
    always @(negedge clk) begin
        ev_t e;
        if (press || key_release) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: press=%0b is_repeat=%0b release=%0b key=(%0d,%0d) at cycle %0d, none expected",
                         press, is_repeat, key_release, key_row, key_col, cyc);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 32'({press, key_release}), 32'({~e.rel, e.rel}));
                check("is_repeat", 32'(is_repeat), 32'(e.rep));
                check("key_row", 32'(key_row), 32'(e.row));
                check("key_col", 32'(key_col), 32'(e.col));
                check("held_at_strobe", 32'(held), 32'(e.hld));
                check("strobe_cycle", cyc, e.due);
            end
        end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL missing_strobe: nothing at cycle %0d, expected release=%0b repeat=%0b key=(%0d,%0d)",
                     e.due, e.rel, e.rep, e.row, e.col);
        end
    end

    initial begin
        ev_t e;
        reset      = 1'b1;
        scan_valid = 1'b0;
        rows       = 4'b0000;
        cols       = 4'b0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_outputs", 32'({press, is_repeat, key_release, held, key_row, key_col}), 0);

        // Key (row 1, col 2): press after the third agreeing sample, then a long hold
        repeat (3) smp(4'b0010, 4'b0100);
        expect_ev(1'b0, 1'b0, 2'd1, 2'd2, 1'b1);
        for (int h = 1; h <= 30; h++) begin
            smp(4'b0010, 4'b0100);
`ifdef KEYPAD_EVENT_REPEAT_EN
            if (h >= 16 && h % 4 == 0) expect_ev(1'b0, 1'b1, 2'd1, 2'd2, 1'b1);
`endif
        end
        idle(1);
        check("held_during_hold", 32'(held), 1);
        repeat (3) smp(4'b0000, 4'b0000);
        expect_ev(1'b1, 1'b0, 2'd1, 2'd2, 1'b0);
        idle(1);
        check("held_after_release", 32'(held), 0);
        check("key_row_retained", 32'(key_row), 1);

        // Two samples then NONE: no press; then key (0,0) for three samples
        repeat (2) smp(4'b0010, 4'b0100);
        smp(4'b0000, 4'b0000);
        repeat (3) smp(4'b0001, 4'b0001);
        expect_ev(1'b0, 1'b0, 2'd0, 2'd0, 1'b1);

        // Release bounce: NONE x2, key x1, NONE x3 gives one release at the end
        repeat (2) smp(4'b0000, 4'b0000);
        smp(4'b0001, 4'b0001);
        idle(1);
        check("held_after_bounce", 32'(held), 1);
        repeat (3) smp(4'b0000, 4'b0000);
        expect_ev(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);

        // MULTI from IDLE never presses
        repeat (5) smp(4'b0011, 4'b0001);
        idle(1);
        check("held_after_multi_idle", 32'(held), 0);

        // Key (3,3), then MULTI and a different key while held: no release, no new press
        repeat (3) smp(4'b1000, 4'b1000);
        expect_ev(1'b0, 1'b0, 2'd3, 2'd3, 1'b1);
        repeat (3) smp(4'b0011, 4'b0001);
        repeat (4) smp(4'b0100, 4'b0010);
        idle(1);
        check("held_multi_in_held", 32'(held), 1);
        check("key_col_unchanged", 32'(key_col), 3);
        repeat (3) smp(4'b0000, 4'b0000);
        expect_ev(1'b1, 1'b0, 2'd3, 2'd3, 1'b0);

        // scan_valid low for 10 cycles mid-debounce: the count resumes where it was
        repeat (2) smp(4'b0100, 4'b0010);
        idle(10);
        check("held_mid_debounce", 32'(held), 0);
        smp(4'b0100, 4'b0010);
        expect_ev(1'b0, 1'b0, 2'd2, 2'd1, 1'b1);

        // Reset while HELD: outputs cleared, no release for the old key
        do_reset(4'b0000, 4'b0000);
        repeat (4) smp(4'b0000, 4'b0000);
        idle(1);
        check("held_after_reset_in_held", 32'(held), 0);

        // Reset in DEB_PRESS with the key still present: the count restarts from zero
        repeat (2) smp(4'b0010, 4'b0010);
        do_reset(4'b0010, 4'b0010);
        repeat (2) smp(4'b0010, 4'b0010);
        idle(1);
        check("held_after_reset_in_deb", 32'(held), 0);
        smp(4'b0010, 4'b0010);
        expect_ev(1'b0, 1'b0, 2'd1, 2'd1, 1'b1);
        repeat (3) smp(4'b0000, 4'b0000);
        expect_ev(1'b1, 1'b0, 2'd1, 2'd1, 1'b0);

        // Drain: anything still queued never appeared
        idle(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL missing_strobe: nothing by end, expected at cycle %0d release=%0b repeat=%0b",
                     e.due, e.rel, e.rep);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_event.md
# keypad_event

Parametrised key-event detector sitting between the keypad scanner and the display/command logic. Per scan sample it classifies the row/column hits, debounces press and release over a configurable number of samples, and emits single-cycle press and release strobes with an encoded key position. A held key produces exactly one press, plus optional typematic auto-repeat.

## Interface
- NROWS, 4, number of keypad rows (≥2)
- NCOLS, 4, number of keypad columns (≥2)
- DEBOUNCE, 3, consecutive agreeing samples needed to accept a press or release (≥1)
- REPEAT_DELAY, 16, samples from accepted press to first repeat (≥1)
- REPEAT_RATE, 4, samples between subsequent repeats (≥1)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- scan_valid  in  1  rows/cols hold a complete scan sample this cycle
- rows  in  NROWS  active-high row hits
- cols  in  NCOLS  active-high column hits
- press  out  1  one-cycle strobe: key accepted (or repeated)
- is_repeat  out  1  qualifies press: 1 = auto-repeat, 0 = fresh press
- release  out  1  one-cycle strobe: held key released
- held  out  1  high from press of a fresh key until its release strobe
- key_row  out  $clog2(NROWS)  row index of the current/last accepted key
- key_col  out  $clog2(NCOLS)  column index of the current/last accepted key

## Operation
- Sample class, evaluated only when scan_valid=1: NONE = rows all 0; SINGLE = exactly one rows bit and exactly one cols bit set; MULTI = anything else.
- Candidate code = binary index of the set row/col bit of a SINGLE sample.
- Sample counter cnt, width $clog2(DEBOUNCE+1); repeat counter rcnt, width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
- States:
  - IDLE: SINGLE → capture candidate, cnt=1, go DEB_PRESS (if DEBOUNCE=1: accept immediately, go HELD). NONE/MULTI → stay.
  - DEB_PRESS: SINGLE, same candidate → cnt+1; on cnt reaching DEBOUNCE accept press, go HELD. SINGLE, different candidate → recapture, cnt=1. NONE/MULTI → IDLE.
  - HELD: NONE → cnt=1, go DEB_REL (if DEBOUNCE=1: release immediately, go IDLE). SINGLE (any code) or MULTI → stay, cnt unchanged; a different key while held is ignored, no new press.
  - DEB_REL: NONE → cnt+1; on cnt reaching DEBOUNCE issue release, go IDLE. SINGLE/MULTI → back to HELD (bounce), no release.
- Accepting press: key_row/key_col load the candidate, held=1, press=1, is_repeat=0, rcnt=0.
- Release: release=1, held=0; key_row/key_col retain last value.
- scan_valid=0: state, cnt and rcnt hold; no strobes.

## Timing
- All outputs registered. press/release assert in the cycle after the clk edge that samples the completing scan_valid, for exactly one cycle.
- key_row/key_col/held change in the same cycle press (fresh) / release asserts.
- press and release never assert in the same cycle; release never asserts without a prior fresh press.
- Reset (any state, mid-debounce or mid-hold): state IDLE, cnt=rcnt=0, press=is_repeat=release=held=0, key_row=key_col=0; no release strobe is generated for a key held across reset.
- Reset takes priority over scan_valid in the same cycle.

## Configuration
- KEYPAD_EVENT_REPEAT_EN defined: in HELD and DEB_REL, rcnt increments per scan_valid sample; when rcnt reaches REPEAT_DELAY (first) then REPEAT_RATE (subsequent) while in HELD, press=1 with is_repeat=1 and rcnt=0; key_row/key_col unchanged. Repeat due while in DEB_REL is deferred: rcnt saturates, repeat fires on the first HELD sample after a bounce, never after release.
- Undefined: no repeat logic; rcnt absent; is_repeat tied 0; press only on fresh accept. REPEAT_* parameters ignored.

## Test plan
- DEBOUNCE=3, rows=0010 cols=0100 for 3 samples → press one cycle after 3rd sample, key_row=1 key_col=2, held=1; 20 more samples → no further press (macro off).
- Same key for 2 samples then NONE → no press, state back to IDLE; then 3 samples rows=0001 cols=0001 → press, key_row=0 key_col=0.
- Held key, NONE ×2 then SINGLE ×1 then NONE ×3 → single release after 3rd NONE, none after the bounce; held drops with release.
- MULTI sample (rows=0011 cols=0001) from IDLE ×5 → no press; MULTI during HELD → held stays 1, no release.
- Macro on, REPEAT_DELAY=16 REPEAT_RATE=4: hold key 30 samples after accept → fresh press, then is_repeat presses at samples 16, 20, 24, 28.
- Reset asserted in DEB_PRESS and in HELD → all outputs 0 next cycle, no release strobe; scan_valid held low for 10 cycles mid-debounce → no state change.
